// File: rtl/regfile_mc.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mc
// Purpose  : Architectural register file and rename/dependency table with
//            NRD read ports, two commit ports and same-cycle commit forwarding.
//            Optional rename-table checkpoint: define REGFILE_CKPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mc #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int ROB_W = 4,
    parameter int NRD   = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         rdy_in,
    input  logic [NRD*$clog2(NREG)-1:0]  rd_id,
    output logic [NRD*XLEN-1:0]          rd_val,
    output logic [NRD-1:0]               rd_has_dep,
    output logic [NRD*ROB_W-1:0]         rd_dep,
    output logic [NRD*ROB_W-1:0]         rob_q_id,
    input  logic [NRD-1:0]               rob_q_avail,
    input  logic [NRD*XLEN-1:0]          rob_q_val,
    input  logic                         ren_valid,
    input  logic [$clog2(NREG)-1:0]      ren_id,
    input  logic [ROB_W-1:0]             ren_tag,
    input  logic [1:0]                   cmt_valid,
    input  logic [2*$clog2(NREG)-1:0]    cmt_id,
    input  logic [2*XLEN-1:0]            cmt_val,
    input  logic [2*ROB_W-1:0]           cmt_tag,
    input  logic                         flush,
    input  logic                         ckpt_save,
    input  logic                         ckpt_restore,
    output logic                         ckpt_valid
);

    localparam int RW = $clog2(NREG);

    logic [XLEN-1:0]  r_regs [NREG];
    logic [NREG-1:0]  r_busy;
    logic [ROB_W-1:0] r_dep  [NREG];

    logic [NREG-1:0]  w_busy_nxt;
    logic [ROB_W-1:0] w_dep_nxt [NREG];
    logic             w_ren_ok;

    assign w_ren_ok = ren_valid && (ren_id != '0);

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RW-1:0]    w_id;
        logic             w_ren_hit;
        logic [ROB_W-1:0] w_dep;
        logic             w_pend;
        logic             w_fwd;
        logic [XLEN-1:0]  w_fwd_val;
        logic [XLEN-1:0]  w_val;
        logic             w_has_dep;

        assign w_id      = rd_id[k*RW +: RW];
        assign w_ren_hit = ren_valid && (ren_id == w_id) && (w_id != '0);
        assign w_dep     = w_ren_hit ? ren_tag : r_dep[w_id];
        assign w_pend    = r_busy[w_id] || w_ren_hit;

        // Ascending scan lets the younger commit port win a tag tie.
        always_comb begin
            w_fwd     = 1'b0;
            w_fwd_val = '0;
            for (int j = 0; j < 2; j++) begin
                if (cmt_valid[j] && (cmt_tag[j*ROB_W +: ROB_W] == w_dep)) begin
                    w_fwd     = 1'b1;
                    w_fwd_val = cmt_val[j*XLEN +: XLEN];
                end
            end
        end

        always_comb begin
            w_val     = '0;
            w_has_dep = 1'b0;
            if (w_pend && w_fwd && !w_ren_hit) begin
                w_val     = w_fwd_val;
                w_has_dep = 1'b0;
            end else if (w_pend) begin
                w_val     = rob_q_val[k*XLEN +: XLEN];
                w_has_dep = !rob_q_avail[k];
            end else if (w_id != '0) begin
                w_val     = r_regs[w_id];
            end
        end

        assign rd_val[k*XLEN +: XLEN]    = w_val;
        assign rd_has_dep[k]             = w_has_dep;
        assign rd_dep[k*ROB_W +: ROB_W]  = w_dep;
        assign rob_q_id[k*ROB_W +: ROB_W] = w_dep;
    end

`ifdef REGFILE_CKPT_EN
    logic [NREG-1:0]  r_snap_busy;
    logic [ROB_W-1:0] r_snap_dep [NREG];
    logic             r_ckpt_valid;
    logic [NREG-1:0]  w_snap_busy_cl;
    logic [ROB_W-1:0] w_snap_dep_cl [NREG];
    logic [NREG-1:0]  w_snap_busy_nxt;
    logic [ROB_W-1:0] w_snap_dep_nxt [NREG];
    logic             w_restore;
    logic             w_ckpt_valid_nxt;

    assign w_restore  = ckpt_restore && r_ckpt_valid && !flush;
    assign ckpt_valid = r_ckpt_valid;

    // Snapshot tracks commits so a restore never resurrects a retired producer.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_snap_busy_cl[i] = r_snap_busy[i];
            w_snap_dep_cl[i]  = r_snap_dep[i];
            for (int j = 0; j < 2; j++) begin
                if (cmt_valid[j] && (cmt_id[j*RW +: RW] == RW'(i)) &&
                    (r_snap_dep[i] == cmt_tag[j*ROB_W +: ROB_W])) begin
                    w_snap_busy_cl[i] = 1'b0;
                    w_snap_dep_cl[i]  = '0;
                end
            end
        end
    end
`else
    logic w_ckpt_unused;

    assign w_ckpt_unused = ckpt_save ^ ckpt_restore;
    assign ckpt_valid    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next rename-table state: commit clear, rename, restore, flush
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_busy_nxt[i] = r_busy[i];
            w_dep_nxt[i]  = r_dep[i];
            for (int j = 0; j < 2; j++) begin
                if (cmt_valid[j] && (cmt_id[j*RW +: RW] == RW'(i)) &&
                    (r_dep[i] == cmt_tag[j*ROB_W +: ROB_W])) begin
                    w_busy_nxt[i] = 1'b0;
                    w_dep_nxt[i]  = '0;
                end
            end
        end
        if (w_ren_ok) begin
            w_busy_nxt[ren_id] = 1'b1;
            w_dep_nxt[ren_id]  = ren_tag;
        end
`ifdef REGFILE_CKPT_EN
        if (w_restore) begin
            w_busy_nxt = w_snap_busy_cl;
            w_dep_nxt  = w_snap_dep_cl;
        end
`endif
        if (flush) begin
            w_busy_nxt = '0;
            for (int i = 0; i < NREG; i++) begin
                w_dep_nxt[i] = '0;
            end
        end
    end

`ifdef REGFILE_CKPT_EN
    always_comb begin
        w_snap_busy_nxt  = ckpt_save ? w_busy_nxt : w_snap_busy_cl;
        w_snap_dep_nxt   = ckpt_save ? w_dep_nxt  : w_snap_dep_cl;
        w_ckpt_valid_nxt = ckpt_save ? 1'b1 : (w_restore ? 1'b0 : r_ckpt_valid);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_snap_busy  <= '0;
            r_ckpt_valid <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_snap_dep[i] <= '0;
            end
        end else if (rdy_in) begin
            r_snap_busy  <= w_snap_busy_nxt;
            r_snap_dep   <= w_snap_dep_nxt;
            r_ckpt_valid <= w_ckpt_valid_nxt;
        end
    end
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
                r_dep[i]  <= '0;
            end
        end else if (rdy_in) begin
            r_busy <= w_busy_nxt;
            r_dep  <= w_dep_nxt;
            for (int j = 0; j < 2; j++) begin
                if (cmt_valid[j] && (cmt_id[j*RW +: RW] != '0)) begin
                    r_regs[cmt_id[j*RW +: RW]] <= cmt_val[j*XLEN +: XLEN];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mc
// Purpose  : Directed self-checking bench for regfile_mc (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mc;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic [9:0]  rd_id;
    logic [63:0] rd_val;
    logic [1:0]  rd_has_dep;
    logic [7:0]  rd_dep;
    logic [7:0]  rob_q_id;
    logic [1:0]  rob_q_avail;
    logic [63:0] rob_q_val;
    logic        ren_valid;
    logic [4:0]  ren_id;
    logic [3:0]  ren_tag;
    logic [1:0]  cmt_valid;
    logic [9:0]  cmt_id;
    logic [63:0] cmt_val;
    logic [7:0]  cmt_tag;
    logic        flush;
    logic        ckpt_save;
    logic        ckpt_restore;
    logic        ckpt_valid;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mc #(.XLEN(32), .NREG(32), .ROB_W(4), .NRD(2)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .rd_id       (rd_id),
        .rd_val      (rd_val),
        .rd_has_dep  (rd_has_dep),
        .rd_dep      (rd_dep),
        .rob_q_id    (rob_q_id),
        .rob_q_avail (rob_q_avail),
        .rob_q_val   (rob_q_val),
        .ren_valid   (ren_valid),
        .ren_id      (ren_id),
        .ren_tag     (ren_tag),
        .cmt_valid   (cmt_valid),
        .cmt_id      (cmt_id),
        .cmt_val     (cmt_val),
        .cmt_tag     (cmt_tag),
        .flush       (flush),
        .ckpt_save   (ckpt_save),
        .ckpt_restore(ckpt_restore),
        .ckpt_valid  (ckpt_valid)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        ren_valid    = 1'b0;
        cmt_valid    = 2'b00;
        flush        = 1'b0;
        ckpt_save    = 1'b0;
        ckpt_restore = 1'b0;
    endtask

    task automatic rd(input int k, input logic [4:0] id);
        rd_id[k*5 +: 5] = id;
    endtask

    task automatic ren(input logic [4:0] id, input logic [3:0] tag);
        ren_valid = 1'b1;
        ren_id    = id;
        ren_tag   = tag;
    endtask

    task automatic cmt(input int j, input logic [4:0] id, input logic [31:0] v, input logic [3:0] t);
        cmt_valid[j]        = 1'b1;
        cmt_id[j*5 +: 5]    = id;
        cmt_val[j*32 +: 32] = v;
        cmt_tag[j*4 +: 4]   = t;
    endtask

    function automatic logic [31:0] val(input int k);
        return rd_val[k*32 +: 32];
    endfunction

    function automatic logic [31:0] hd(input int k);
        return 32'(rd_has_dep[k]);
    endfunction

    function automatic logic [31:0] dep(input int k);
        return 32'(rd_dep[k*4 +: 4]);
    endfunction

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1;
        rd_id = '0; rob_q_avail = '0; rob_q_val = '0;
        ren_id = '0; ren_tag = '0; cmt_id = '0; cmt_val = '0; cmt_tag = '0;
        idle();
        rd(0, 5'd5); rd(1, 5'd0);
        repeat (2) tick();
        #1;
        chk("rst_val_x5", val(0), 32'h0);
        chk("rst_hd_x5", hd(0), 32'h0);
        chk("rst_ckpt_valid", 32'(ckpt_valid), 32'h0);
        rst_n_in = 1'b1;
        tick();

        // rename to x0 is ignored
        ren(5'd0, 4'd3); rd(0, 5'd0); #1;
        chk("x0_ren_same_hd", hd(0), 32'h0);
        tick(); idle(); #1;
        chk("x0_after_hd", hd(0), 32'h0);
        chk("x0_after_val", val(0), 32'h0);

        // rename x3 -> 7 with same-cycle read
        ren(5'd3, 4'd7); rd(0, 5'd3); #1;
        chk("ren_same_hd", hd(0), 32'h1);
        chk("ren_same_dep", dep(0), 32'h7);
        chk("ren_same_qid", 32'(rob_q_id[3:0]), 32'h7);
        tick(); idle();
        rob_q_avail = 2'b01; rob_q_val[31:0] = 32'h55; rd(1, 5'd3); #1;
        chk("rob_val", val(0), 32'h55);
        chk("rob_hd", hd(0), 32'h0);
        chk("rob_p1_hd", hd(1), 32'h1);
        chk("rob_p1_dep", dep(1), 32'h7);

        // commit forwarding, then architectural value
        rob_q_avail = 2'b00;
        cmt(0, 5'd3, 32'hAB, 4'd7); #1;
        chk("fwd_val", val(0), 32'hAB);
        chk("fwd_hd", hd(0), 32'h0);
        tick(); idle(); #1;
        chk("cmt_x3_hd", hd(0), 32'h0);
        chk("cmt_x3_val", val(0), 32'hAB);

        // dual commit to x4, younger port wins the write
        ren(5'd4, 4'd3);
        tick(); idle();
        cmt(0, 5'd4, 32'h1, 4'd2); cmt(1, 5'd4, 32'h2, 4'd3); rd(1, 5'd4); #1;
        chk("dual_fwd_val", val(1), 32'h2);
        chk("dual_fwd_hd", hd(1), 32'h0);
        tick(); idle(); #1;
        chk("dual_x4_val", val(1), 32'h2);
        chk("dual_x4_hd", hd(1), 32'h0);

        // commit of old producer while renaming keeps new dependency
        ren(5'd3, 4'd7);
        tick(); idle();
        cmt(0, 5'd3, 32'h77, 4'd7); ren(5'd3, 4'd9); rd(0, 5'd3); #1;
        chk("cmtren_same_hd", hd(0), 32'h1);
        chk("cmtren_same_dep", dep(0), 32'h9);
        tick(); idle(); #1;
        chk("cmtren_next_hd", hd(0), 32'h1);
        chk("cmtren_next_dep", dep(0), 32'h9);

        // forwarding tag tie resolved to port 1
        ren(5'd9, 4'd5);
        tick(); idle();
        cmt(0, 5'd10, 32'h10, 4'd5); cmt(1, 5'd11, 32'h11, 4'd5); rd(1, 5'd9); #1;
        chk("tie_val", val(1), 32'h11);
        chk("tie_hd", hd(1), 32'h0);
        tick(); idle();
        rd(0, 5'd10); rd(1, 5'd11); #1;
        chk("tie_x10", val(0), 32'h10);
        chk("tie_x11", val(1), 32'h11);

        // flush clears table, commits still land, rename dropped
        flush = 1'b1; cmt(0, 5'd6, 32'h66, 4'd15); ren(5'd5, 4'd4);
        tick(); idle();
        rd(0, 5'd3); rd(1, 5'd6); #1;
        chk("flush_x3_hd", hd(0), 32'h0);
        chk("flush_x3_val", val(0), 32'h77);
        chk("flush_x6_val", val(1), 32'h66);
        rd(0, 5'd5); rd(1, 5'd9); #1;
        chk("flush_x5_hd", hd(0), 32'h0);
        chk("flush_x9_hd", hd(1), 32'h0);

        // rdy_in low freezes state
        rdy_in = 1'b0; ren(5'd7, 4'd1); cmt(0, 5'd7, 32'h99, 4'd1); rd(0, 5'd7); #1;
        chk("frz_comb_hd", hd(0), 32'h1);
        chk("frz_comb_dep", dep(0), 32'h1);
        tick(); rdy_in = 1'b1; idle(); #1;
        chk("frz_x7_hd", hd(0), 32'h0);
        chk("frz_x7_val", val(0), 32'h0);

`ifdef REGFILE_CKPT_EN
        // checkpoint save / restore
        rob_q_avail = 2'b00;
        ren(5'd1, 4'd2);
        tick(); idle();
        ckpt_save = 1'b1;
        tick(); idle(); #1;
        chk("ckpt_saved", 32'(ckpt_valid), 32'h1);
        ren(5'd1, 4'd5);
        tick(); idle();
        ren(5'd8, 4'd6);
        tick(); idle();
        cmt(0, 5'd1, 32'h22, 4'd2);
        tick(); idle();
        rd(0, 5'd1); rd(1, 5'd8); #1;
        chk("ckpt_live_x1_dep", dep(0), 32'h5);
        chk("ckpt_live_x1_hd", hd(0), 32'h1);
        ckpt_restore = 1'b1;
        tick(); idle(); #1;
        chk("ckpt_x1_hd", hd(0), 32'h0);
        chk("ckpt_x8_hd", hd(1), 32'h0);
        chk("ckpt_cleared", 32'(ckpt_valid), 32'h0);
`else
        ckpt_save = 1'b1; ckpt_restore = 1'b1;
        tick(); idle(); #1;
        chk("ckpt_disabled", 32'(ckpt_valid), 32'h0);
`endif

        // asynchronous reset mid-cycle
        rd(0, 5'd4); #1;
        chk("pre_arst_x4", val(0), 32'h2);
        #1 rst_n_in = 1'b0;
        #1;
        chk("arst_x4", val(0), 32'h0);
        rst_n_in = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
